// File: rtl/unidad_control.sv
// -----------------------------------------------------------------------------
// unidad_control
//   Instruction decoder and two-phase (FETCH/EXEC) control sequencer for the
//   4-bit processor. It also holds the registered carry/zero flags.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   instr      in   [3:0] opcode from the fetch register (valid in EXEC)
//   carry      in   ALU carry/borrow
//   zero       in   ALU zero flag
//   phase      out  0 = FETCH, 1 = EXEC
//   fetch_ena  out  fetch register capture enable
//   pc_inc     out  PC increment strobe
//   pc_load    out  PC load strobe (jump taken)
//   oe_oprnd   out  operand nibble drives the data bus
//   oe_ram     out  RAM drives the data bus
//   oe_in      out  input port drives the data bus
//   ena_tri_1  out  bus -> ALU B buffer enable
//   ena_tri_2  out  ALU result -> bus buffer enable
//   ena_acu    out  accumulator load
//   funcion    out  [2:0] ALU function (000 A, 001 A-B, 010 B, 011 A+B, 100 NAND)
//   cs_ram     out  RAM chip select
//   we_ram     out  RAM write enable
//   load_out   out  output port register load
//   flag_c     out  registered carry flag
//   flag_z     out  registered zero flag
// -----------------------------------------------------------------------------
module unidad_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] instr,
   input  logic       carry,
   input  logic       zero,
   output logic       phase,
   output logic       fetch_ena,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       oe_oprnd,
   output logic       oe_ram,
   output logic       oe_in,
   output logic       ena_tri_1,
   output logic       ena_tri_2,
   output logic       ena_acu,
   output logic [2:0] funcion,
   output logic       cs_ram,
   output logic       we_ram,
   output logic       load_out,
   output logic       flag_c,
   output logic       flag_z
);

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } phase_e;

   typedef enum logic [3:0] {
      OP_JC    = 4'b0000,
      OP_JNC   = 4'b0001,
      OP_CMPI  = 4'b0010,
      OP_CMPM  = 4'b0011,
      OP_LIT   = 4'b0100,
      OP_IN    = 4'b0101,
      OP_LD    = 4'b0110,
      OP_ST    = 4'b0111,
      OP_JZ    = 4'b1000,
      OP_JNZ   = 4'b1001,
      OP_ADDI  = 4'b1010,
      OP_ADDM  = 4'b1011,
      OP_JMP   = 4'b1100,
      OP_OUT   = 4'b1101,
      OP_NANDI = 4'b1110,
      OP_NANDM = 4'b1111
   } opcode_e;

   localparam logic [2:0] FN_A    = 3'b000;
   localparam logic [2:0] FN_SUB  = 3'b001;
   localparam logic [2:0] FN_B    = 3'b010;
   localparam logic [2:0] FN_ADD  = 3'b011;
   localparam logic [2:0] FN_NAND = 3'b100;

   phase_e phase_q, phase_d;
   logic   flag_c_q, flag_z_q;
   logic   flag_upd;   // EXEC of a flag-updating opcode

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q  <= FETCH;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         if (flag_upd) begin
            flag_c_q <= carry;
            flag_z_q <= zero;
         end
      end
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      phase_d   = (phase_q == FETCH) ? EXEC : FETCH;
      flag_upd  = 1'b0;
      fetch_ena = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      oe_oprnd  = 1'b0;
      oe_ram    = 1'b0;
      oe_in     = 1'b0;
      ena_tri_1 = 1'b0;
      ena_tri_2 = 1'b0;
      ena_acu   = 1'b0;
      funcion   = FN_A;
      cs_ram    = 1'b0;
      we_ram    = 1'b0;
      load_out  = 1'b0;

      // Reset silences every strobe, which also aborts an in-flight EXEC.
      if (!reset) begin
         if (phase_q == FETCH) begin
            fetch_ena = 1'b1;
            pc_inc    = 1'b1;
         end else begin
            unique case (opcode_e'(instr))
               // Conditional jumps: a taken branch loads the PC, otherwise the
               // PC skips the address byte.
               OP_JC:  begin pc_load = flag_c_q;  pc_inc = ~flag_c_q; end
               OP_JNC: begin pc_load = ~flag_c_q; pc_inc = flag_c_q;  end
               OP_JZ:  begin pc_load = flag_z_q;  pc_inc = ~flag_z_q; end
               OP_JNZ: begin pc_load = ~flag_z_q; pc_inc = flag_z_q;  end
               OP_JMP: pc_load = 1'b1;
               OP_CMPI: begin
                  oe_oprnd = 1'b1; ena_tri_1 = 1'b1; funcion = FN_SUB; flag_upd = 1'b1;
               end
               OP_CMPM: begin
                  oe_ram = 1'b1; cs_ram = 1'b1; ena_tri_1 = 1'b1; funcion = FN_SUB;
                  flag_upd = 1'b1; pc_inc = 1'b1;
               end
               OP_LIT: begin
                  oe_oprnd = 1'b1; ena_tri_1 = 1'b1; funcion = FN_B; ena_acu = 1'b1;
               end
               OP_IN: begin
                  oe_in = 1'b1; ena_tri_1 = 1'b1; funcion = FN_B; ena_acu = 1'b1;
               end
               OP_LD: begin
                  oe_ram = 1'b1; cs_ram = 1'b1; ena_tri_1 = 1'b1; funcion = FN_B;
                  ena_acu = 1'b1; pc_inc = 1'b1;
               end
               OP_ST: begin
                  funcion = FN_A; ena_tri_2 = 1'b1; cs_ram = 1'b1; we_ram = 1'b1;
                  pc_inc = 1'b1;
               end
               OP_ADDI, OP_NANDI: begin
                  oe_oprnd = 1'b1; ena_tri_1 = 1'b1; ena_acu = 1'b1; flag_upd = 1'b1;
                  funcion = (instr == OP_ADDI) ? FN_ADD : FN_NAND;
               end
               OP_ADDM, OP_NANDM: begin
                  oe_ram = 1'b1; cs_ram = 1'b1; ena_tri_1 = 1'b1; ena_acu = 1'b1;
                  flag_upd = 1'b1; pc_inc = 1'b1;
                  funcion = (instr == OP_ADDM) ? FN_ADD : FN_NAND;
               end
               OP_OUT: begin
                  funcion = FN_A; ena_tri_2 = 1'b1; load_out = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign phase  = (phase_q == EXEC) & ~reset;
   assign flag_c = flag_c_q & ~reset;
   assign flag_z = flag_z_q & ~reset;

endmodule

// File: tb/tb_unidad_control.sv
// -----------------------------------------------------------------------------
// tb_unidad_control
//   Self-checking bench for unidad_control. A table of one-cycle vectors
//   (inputs + hand-computed expected output word) walks through reset, every
//   instruction class, flag hand-off to branches and a reset during EXEC.
//   An opcode sweep with random ALU flags follows, while a monitor checks bus
//   and PC-strobe exclusivity every cycle.
// -----------------------------------------------------------------------------
module tb_unidad_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] instr;
   logic       carry, zero;
   logic       phase, fetch_ena, pc_inc, pc_load, oe_oprnd, oe_ram, oe_in;
   logic       ena_tri_1, ena_tri_2, ena_acu, cs_ram, we_ram, load_out;
   logic       flag_c, flag_z;
   logic [2:0] funcion;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unidad_control dut (
      .clk       (clk),
      .reset     (reset),
      .instr     (instr),
      .carry     (carry),
      .zero      (zero),
      .phase     (phase),
      .fetch_ena (fetch_ena),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .oe_oprnd  (oe_oprnd),
      .oe_ram    (oe_ram),
      .oe_in     (oe_in),
      .ena_tri_1 (ena_tri_1),
      .ena_tri_2 (ena_tri_2),
      .ena_acu   (ena_acu),
      .funcion   (funcion),
      .cs_ram    (cs_ram),
      .we_ram    (we_ram),
      .load_out  (load_out),
      .flag_c    (flag_c),
      .flag_z    (flag_z)
   );

   // Output word layout, MSB first.
   localparam logic [17:0] PH   = 18'h1 << 17;
   localparam logic [17:0] FE   = 18'h1 << 16;
   localparam logic [17:0] PI   = 18'h1 << 15;
   localparam logic [17:0] PL   = 18'h1 << 14;
   localparam logic [17:0] OO   = 18'h1 << 13;
   localparam logic [17:0] ORAM = 18'h1 << 12;
   localparam logic [17:0] OI   = 18'h1 << 11;
   localparam logic [17:0] T1   = 18'h1 << 10;
   localparam logic [17:0] T2   = 18'h1 << 9;
   localparam logic [17:0] ACU  = 18'h1 << 8;
   localparam logic [17:0] CS   = 18'h1 << 4;
   localparam logic [17:0] WE   = 18'h1 << 3;
   localparam logic [17:0] LO   = 18'h1 << 2;
   localparam logic [17:0] FC   = 18'h1 << 1;
   localparam logic [17:0] FZ   = 18'h1;
   localparam logic [17:0] F    = FE | PI;   // FETCH pattern

   function automatic logic [17:0] fn(input logic [2:0] code);
      return {10'b0, code, 5'b0};
   endfunction

   logic [17:0] act;
   assign act = {phase, fetch_ena, pc_inc, pc_load, oe_oprnd, oe_ram, oe_in,
                 ena_tri_1, ena_tri_2, ena_acu, funcion, cs_ram, we_ram,
                 load_out, flag_c, flag_z};

   typedef struct {
      logic        rst;
      logic [3:0]  op;
      logic        c;
      logic        z;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] op, input logic c,
                      input logic z, input logic [17:0] exp);
      vec_t v;
      v.rst = rst; v.op = op; v.c = c; v.z = z; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive on the falling edge, sample 1 ns later, well before the rising edge.
   task automatic apply(input logic rst, input logic [3:0] op, input logic c,
                        input logic z);
      @(negedge clk);
      reset = rst; instr = op; carry = c; zero = z;
      #1;
   endtask

   // Exclusivity monitor, sampled mid-low-phase every cycle.
   always @(negedge clk) begin
      #2;
      check("bus_exclusive", 32'($countones({oe_oprnd, oe_ram, oe_in, ena_tri_2}) <= 1), 32'd1);
      check("pc_excl", 32'(pc_inc & pc_load), 32'd0);
   end

   initial begin
      reset = 1'b1; instr = 4'b1111; carry = 1'b1; zero = 1'b1;

      // reset held 3 cycles: everything zero
      add(1, 4'b1111, 1, 1, 18'h0);
      add(1, 4'b1111, 1, 1, 18'h0);
      add(1, 4'b1111, 1, 1, 18'h0);
      // LIT (carry/zero toggling must not touch flags)
      add(0, 4'b0100, 0, 0, F);
      add(0, 4'b0100, 1, 1, PH | OO | T1 | fn(3'b010) | ACU);
      // ADDI carry=1 zero=0
      add(0, 4'b1010, 1, 1, F);
      add(0, 4'b1010, 1, 0, PH | OO | T1 | fn(3'b011) | ACU);
      // CMPI zero=1 -> flags c=0 z=1
      add(0, 4'b0010, 0, 0, F | FC);
      add(0, 4'b0010, 0, 1, PH | OO | T1 | fn(3'b001) | FC);
      // JZ taken
      add(0, 4'b1000, 1, 0, F | FZ);
      add(0, 4'b1000, 1, 0, PH | PL | FZ);
      // CMPI carry=1 zero=0 -> flags c=1 z=0
      add(0, 4'b0010, 0, 1, F | FZ);
      add(0, 4'b0010, 1, 0, PH | OO | T1 | fn(3'b001) | FZ);
      // JZ not taken
      add(0, 4'b1000, 0, 1, F | FC);
      add(0, 4'b1000, 0, 1, PH | PI | FC);
      // JNC with flag_c=1: not taken
      add(0, 4'b0001, 0, 1, F | FC);
      add(0, 4'b0001, 0, 1, PH | PI | FC);
      // JMP always taken
      add(0, 4'b1100, 0, 1, F | FC);
      add(0, 4'b1100, 0, 1, PH | PL | FC);
      // ST
      add(0, 4'b0111, 0, 0, F | FC);
      add(0, 4'b0111, 0, 0, PH | T2 | CS | WE | PI | FC);
      // LD
      add(0, 4'b0110, 0, 0, F | FC);
      add(0, 4'b0110, 0, 0, PH | ORAM | CS | T1 | fn(3'b010) | ACU | PI | FC);
      // JC with flag_c=1: taken
      add(0, 4'b0000, 0, 0, F | FC);
      add(0, 4'b0000, 0, 0, PH | PL | FC);
      // OUT
      add(0, 4'b1101, 0, 0, F | FC);
      add(0, 4'b1101, 0, 0, PH | T2 | LO | FC);
      // NANDM carry=0 zero=1 -> flags c=0 z=1
      add(0, 4'b1111, 1, 0, F | FC);
      add(0, 4'b1111, 0, 1, PH | ORAM | CS | T1 | fn(3'b100) | ACU | PI | FC);
      // JNZ with flag_z=1: not taken
      add(0, 4'b1001, 0, 0, F | FZ);
      add(0, 4'b1001, 0, 0, PH | PI | FZ);
      // IN
      add(0, 4'b0101, 0, 0, F | FZ);
      add(0, 4'b0101, 0, 0, PH | OI | T1 | fn(3'b010) | ACU | FZ);
      // CMPM carry=1 zero=1 -> flags 11
      add(0, 4'b0011, 0, 0, F | FZ);
      add(0, 4'b0011, 1, 1, PH | ORAM | CS | T1 | fn(3'b001) | PI | FZ);
      // ADDM aborted by reset in EXEC: silent cycle, flags cleared, then FETCH
      add(0, 4'b1011, 0, 0, F | FC | FZ);
      add(1, 4'b1011, 1, 0, 18'h0);
      add(0, 4'b0001, 1, 0, F);
      // JNC with flag_c=0: taken
      add(0, 4'b0001, 1, 0, PH | PL);
      // NANDI carry=0 zero=1
      add(0, 4'b1110, 0, 0, F);
      add(0, 4'b1110, 0, 1, PH | OO | T1 | fn(3'b100) | ACU);
      add(0, 4'b0100, 0, 0, F | FZ);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].op, vecs[i].c, vecs[i].z);
         check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
      end

      // Flags must hold across a FETCH even with carry/zero toggling.
      apply(0, 4'b0100, 1, 0);
      check("hold_lit_exec", 32'(act), 32'(PH | OO | T1 | fn(3'b010) | ACU | FZ));
      apply(0, 4'b0000, 1, 0);
      check("hold_fetch", 32'({flag_c, flag_z}), 32'd1);

      // Opcode sweep with random ALU flags; phase must alternate.
      for (int r = 0; r < 3; r++) begin
         for (int op = 0; op < 16; op++) begin
            apply(0, 4'(op), 1'($urandom_range(1)), 1'($urandom_range(1)));
            check("sweep_exec_phase", 32'(phase), 32'd1);
            apply(0, 4'(op), 1'($urandom_range(1)), 1'($urandom_range(1)));
            check("sweep_fetch", 32'({phase, fetch_ena, pc_inc, pc_load}), 32'b0110);
         end
      end

      @(negedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
